// File: rtl/conv2d_stream_if.sv
// Pixel-in / result-out stream bundle for conv2d_stream.
// slave: the convolution engine; master: the pixel source and result sink.
interface conv2d_stream_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 20
) ();
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] pix_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;

   modport slave (
      input  pix_valid, pix_data, out_ready,
      output pix_ready, out_valid, out_data
   );

   modport master (
      output pix_valid, pix_data, out_ready,
      input  pix_ready, out_valid, out_data
   );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming 3x3 valid-mode convolution over an IMG_H x IMG_W raster image.
// Two shift-register line buffers supply the upper two rows of each column;
// a two-column window register plus the incoming column forms the 3x3 patch.
// Optional macro CONV_RELU_EN: clamp negative results to zero before output.
module conv2d_stream #(
   parameter int unsigned IMG_W  = 8,
   parameter int unsigned IMG_H  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned ACC_W  = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [9*COEF_W-1:0] kernel_i,
   output logic                busy_o,
   output logic                done_o,
   conv2d_stream_if.slave      bus
);

   localparam int unsigned ColW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned RowW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int unsigned SumRaw = DATA_W + COEF_W + 5;
   localparam int unsigned SumW   = (SumRaw > ACC_W) ? SumRaw : ACC_W;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                     state_q, state_d;
   logic [ColW-1:0]            col_q;
   logic [RowW-1:0]            row_q;
   logic signed [COEF_W-1:0]   kernel_q [9];
   logic [DATA_W-1:0]          lb1_q [IMG_W];
   logic [DATA_W-1:0]          lb2_q [IMG_W];
   logic [DATA_W-1:0]          win_q [3][2];
   logic                       out_valid_q, out_valid_d;
   logic [ACC_W-1:0]           out_data_q, out_data_d;
   logic                       done_q, done_d;

   logic                       load_k, accept, last_pix, win_done;
   logic [DATA_W-1:0]          col_pix [3];
   logic [DATA_W-1:0]          tap [9];
   logic signed [SumW-1:0]     sum;
   logic [ACC_W-1:0]           res;

   assign bus.pix_ready = (state_q == StRun) && !(out_valid_q && !bus.out_ready);
   assign accept        = bus.pix_valid && bus.pix_ready;
   assign last_pix      = (row_q == RowW'(IMG_H - 1)) && (col_q == ColW'(IMG_W - 1));
   assign win_done      = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy_o        = (state_q != StIdle);
   assign done_o        = done_q;

   // Column entering the window: two rows up, one row up, current pixel.
   assign col_pix[0] = lb2_q[IMG_W-1];
   assign col_pix[1] = lb1_q[IMG_W-1];
   assign col_pix[2] = bus.pix_data;

   // State, done pulse and frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (load_k) begin
            col_q <= '0;
            row_q <= '0;
         end else if (accept) begin
            if (col_q == ColW'(IMG_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + RowW'(1);
            end else begin
               col_q <= col_q + ColW'(1);
            end
         end
      end
   end

   // Next state: frame start, end of pixel input, drain of the last result.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load_k  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRun;
               load_k  = 1'b1;
            end
         end
         StRun: begin
            if (accept && last_pix) state_d = StDrain;
         end
         StDrain: begin
            if (!out_valid_q || bus.out_ready) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Kernel is captured once per frame so mid-frame kernel_i changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) kernel_q[i] <= '0;
      end else if (load_k) begin
         for (int i = 0; i < 9; i++) kernel_q[i] <= kernel_i[i*COEF_W +: COEF_W];
      end
   end

   // Line buffers and window shift on every accepted pixel; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[0] <= bus.pix_data;
         lb2_q[0] <= lb1_q[IMG_W-1];
         for (int i = 1; i < IMG_W; i++) begin
            lb1_q[i] <= lb1_q[i-1];
            lb2_q[i] <= lb2_q[i-1];
         end
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= col_pix[r];
         end
      end
   end

   // Multiply-accumulate over the 3x3 patch; pixels zero-extended, coefficients sign-extended.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         tap[r*3]     = win_q[r][0];
         tap[r*3 + 1] = win_q[r][1];
         tap[r*3 + 2] = col_pix[r];
      end
      sum = '0;
      for (int i = 0; i < 9; i++) begin
         sum = sum + SumW'($signed({1'b0, tap[i]})) * SumW'(kernel_q[i]);
      end
      res = sum[ACC_W-1:0];
`ifdef CONV_RELU_EN
      if (res[ACC_W-1]) res = '0;
`endif
   end

   // Single output register: load on a completed window, clear when taken.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (win_done) begin
         out_valid_d = 1'b1;
         out_data_d  = res;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming 3x3 2-D convolution engine for the CNN accelerator. It accepts an IMG_H x IMG_W image one pixel per beat in raster order and keeps the last two image rows in internal line buffers. It emits the (IMG_H-2) x (IMG_W-2) valid-mode feature map (stride 1, no padding) as signed results over a valid/ready stream. It is the sequential, parametrised successor to the combinational single-bit convolution layer and feeds the pooling/activation stage downstream.

## Interface
Parameters:
- IMG_W, 8: image width in pixels; must be ≥ 3.
- IMG_H, 8: image height in pixels; must be ≥ 3.
- DATA_W, 8: pixel width, unsigned.
- COEF_W, 8: kernel coefficient width, signed two's complement.
- ACC_W, 20: result width, signed.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- kernel_in  in  9*COEF_W  coefficients. k[r][c] = kernel_in[(r*3+c)*COEF_W +: COEF_W], where r=0 is the top row and c=0 is the left column.
- pix_valid  in  1  pixel beat valid.
- pix_ready  out  1  engine can accept a pixel.
- pix_data  in  DATA_W  pixel, raster order (row 0 col 0 first).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  convolution result, signed.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last result has been accepted.

## Operation
- FSM states:
  - IDLE: on start, latch kernel_in into an internal register, clear the row/col counters, go to RUN.
  - RUN: accept pixels. After the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: wait until the output register is empty (the last result has been accepted), then pulse done and go to IDLE.
- A pixel transfer happens on a cycle where pix_valid && pix_ready. The col counter wraps at IMG_W-1, and the row counter then increments.
- Line buffers: two IMG_W-deep rows. Each accepted pixel shifts its column through the buffers, and a 3x3 window register shifts left by one column.
- A window is complete when the accepted pixel has row ≥ 2 and col ≥ 2. Its result is out = Σ k[r][c] · pix(row-2+r, col-2+c), with the pixel zero-extended and the coefficient sign-extended. The sum is computed at full width and truncated to ACC_W (two's-complement wrap). ACC_W ≥ DATA_W+COEF_W+4 guarantees no wrap.
- Results leave in raster order: exactly (IMG_H-2)*(IMG_W-2) results per frame, which is 36 for 8x8.
- Output stage: a single register.
  - pix_ready = (state==RUN) && !(out_valid && !out_ready).
  - The register holds its value while out_valid && !out_ready.
- Kernel latched at start is used for the entire frame. Changes to kernel_in mid-frame have no effect.
- A start pulse in RUN or DRAIN is ignored.
- pix_valid outside RUN is ignored; no transfer occurs.

## Timing
- Reset values: pix_ready=0, out_valid=0, out_data=0, busy=0, done=0, state=IDLE, counters=0. Line buffers and the window register are not reset and their contents are don't-care.
- start at cycle t leads to busy=1 and pix_ready=1 at t+1.
- Latency: the result for the window completed by the pixel accepted at cycle t appears with out_valid=1 at t+1.
- Throughput is one pixel per cycle with out_ready held high. The first result comes 2*IMG_W+3 accepted pixels after start.
- done asserts the cycle after the final out transfer. busy drops in that same cycle.
- Asserting rst_n low mid-frame immediately returns the block to IDLE with all outputs at their reset values. No partial frame resumes afterwards.

## Configuration
- CONV_RELU_EN:
  - Defined: a result < 0 is written as 0 to the output register (ReLU fused in).
  - Undefined: the signed result passes through unchanged.
  - Latency is identical either way.

## Test plan
- Identity kernel (k[1][1]=1, others 0), 8x8 ramp pix=r*8+c, out_ready=1 -> 36 results, result i,j = (i+1)*8+(j+1), so the first is 9 and the last is 54. done fires once.
- All-ones kernel, constant image 2 -> 36 results of 18. The first out_valid arrives exactly one cycle after the 19th pixel transfer.
- Kernel k[1][1]=-1, constant image 5 -> every result is -5 (0x FFFFB at ACC_W=20) without CONV_RELU_EN, and 0 with it.
- Identity kernel with out_ready held low for 10 cycles in mid-frame -> pix_ready drops while the output register is full, out_data stays stable, and no result is lost or duplicated (36 total, correct order).
- Assert rst_n low after 30 pixels, release, start a new frame -> outputs at reset values during reset. The new frame produces 36 correct results with no residue from the aborted frame.
- Pulse start again during RUN with a different kernel_in -> the pulse is ignored and results match the originally latched kernel.
